// File: rtl/branch_predict_unit_if.sv
// Predict and resolve port bundle between fetch, execute and the branch predictor.
interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pred_pc;
   logic            pred_taken;

   logic            res_valid;
   logic [XLEN-1:0] res_pc;
   logic [2:0]      res_funct3;
   logic [XLEN-1:0] res_rs1;
   logic [XLEN-1:0] res_rs2;
   logic [XLEN-1:0] res_imm;
   logic            res_pred_taken;

   logic            out_valid;
   logic            out_taken;
   logic            out_mispredict;
   logic            out_illegal;
   logic [XLEN-1:0] out_next_pc;

   modport master (
      output pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_imm, res_pred_taken,
      input  pred_taken, out_valid, out_taken, out_mispredict, out_illegal, out_next_pc
   );

   modport slave (
      input  pred_pc, res_valid, res_pc, res_funct3, res_rs1, res_rs2, res_imm, res_pred_taken,
      output pred_taken, out_valid, out_taken, out_mispredict, out_illegal, out_next_pc
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch condition evaluation, next-PC resolution and bimodal 2-bit prediction table.
module branch_predict_unit #(
   parameter int         XLEN         = 32,
   parameter int         BHT_ENTRIES  = 64,
   parameter logic [1:0] COUNTER_INIT = 2'b01,
   parameter int         CNT_W        = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   branch_predict_unit_if.slave bus,
   output logic [CNT_W-1:0]     stat_branches,
   output logic [CNT_W-1:0]     stat_mispredicts
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];
   logic             out_valid_q, out_valid_d;
   logic             out_taken_q, out_taken_d;
   logic             out_mis_q, out_mis_d;
   logic             out_ill_q, out_ill_d;
   logic [XLEN-1:0]  out_npc_q, out_npc_d;
   logic [CNT_W-1:0] stat_br_q, stat_br_d;
   logic [CNT_W-1:0] stat_mis_q, stat_mis_d;

   logic             eq, lt_s, lt_u, illegal, taken, mispredict;
   logic [IDX_W-1:0] pred_idx, res_idx;
   logic [1:0]       cur_ctr;

   assign pred_idx = bus.pred_pc[IDX_W+1:2];
   assign res_idx  = bus.res_pc[IDX_W+1:2];

   // Prediction reads the registered counter, so a same-cycle update is not visible yet
   assign bus.pred_taken = bht_q[pred_idx][1];

   // Evaluate the branch condition straight from the operands
   always_comb begin
      eq      = (bus.res_rs1 == bus.res_rs2);
      lt_s    = ($signed(bus.res_rs1) < $signed(bus.res_rs2));
      lt_u    = (bus.res_rs1 < bus.res_rs2);
      illegal = (bus.res_funct3 == 3'b010) || (bus.res_funct3 == 3'b011);
      taken   = 1'b0;
      case (bus.res_funct3)
         3'b000:  taken = eq;
         3'b001:  taken = !eq;
         3'b100:  taken = lt_s;
         3'b101:  taken = !lt_s;
         3'b110:  taken = lt_u;
         3'b111:  taken = !lt_u;
         default: taken = 1'b0;
      endcase
      mispredict = !illegal && (taken != bus.res_pred_taken);
   end

   // Next-state for result registers, prediction table and statistics
   always_comb begin
      out_valid_d = bus.res_valid;
      out_taken_d = out_taken_q;
      out_mis_d   = out_mis_q;
      out_ill_d   = out_ill_q;
      out_npc_d   = out_npc_q;
      bht_d       = bht_q;
      stat_br_d   = stat_br_q;
      stat_mis_d  = stat_mis_q;
      cur_ctr     = bht_q[res_idx];
      if (bus.res_valid) begin
         out_taken_d = taken;
         out_mis_d   = mispredict;
         out_ill_d   = illegal;
         out_npc_d   = taken ? (bus.res_pc + bus.res_imm) : (bus.res_pc + PC_STEP);
         if (!illegal) begin
            if (taken && cur_ctr != 2'b11) begin
               bht_d[res_idx] = cur_ctr + 2'b01;
            end else if (!taken && cur_ctr != 2'b00) begin
               bht_d[res_idx] = cur_ctr - 2'b01;
            end
            if (stat_br_q != CNT_MAX) begin
               stat_br_d = stat_br_q + CNT_W'(1);
            end
            if (mispredict && stat_mis_q != CNT_MAX) begin
               stat_mis_d = stat_mis_q + CNT_W'(1);
            end
         end
      end
   end

   // State registers; reset discards any resolve presented in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_taken_q <= 1'b0;
         out_mis_q   <= 1'b0;
         out_ill_q   <= 1'b0;
         out_npc_q   <= '0;
         stat_br_q   <= '0;
         stat_mis_q  <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= COUNTER_INIT;
         end
      end else begin
         out_valid_q <= out_valid_d;
         out_taken_q <= out_taken_d;
         out_mis_q   <= out_mis_d;
         out_ill_q   <= out_ill_d;
         out_npc_q   <= out_npc_d;
         stat_br_q   <= stat_br_d;
         stat_mis_q  <= stat_mis_d;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= bht_d[i];
         end
      end
   end

   assign bus.out_valid      = out_valid_q;
   assign bus.out_taken      = out_taken_q;
   assign bus.out_mispredict = out_mis_q;
   assign bus.out_illegal    = out_ill_q;
   assign bus.out_next_pc    = out_npc_q;
   assign stat_branches      = stat_br_q;
   assign stat_mispredicts   = stat_mis_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: expected results queued at drive time, checked at output.
module tb_branch_predict_unit;
   localparam int XLEN = 32;
   localparam int BHT  = 64;
   localparam int CNTW = 32;

   typedef struct {
      logic            taken;
      logic            mis;
      logic            ill;
      logic [XLEN-1:0] npc;
      logic [CNTW-1:0] sb;
      logic [CNTW-1:0] sm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [CNTW-1:0] stat_branches, stat_mispredicts;

   branch_predict_unit_if #(.XLEN(XLEN)) bus ();

   branch_predict_unit #(
      .XLEN(XLEN), .BHT_ENTRIES(BHT), .COUNTER_INIT(2'b01), .CNT_W(CNTW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   exp_t sb_q[$];
   int model_ctr [BHT];
   logic [CNTW-1:0] m_sb, m_sm;
   logic [XLEN-1:0] last_npc;
   logic            last_taken;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [XLEN-1:0] pc);
      return int'(pc[7:2]);
   endfunction

   function automatic logic model_pred(input logic [XLEN-1:0] pc);
      return model_ctr[idx_of(pc)] >= 2;
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) < $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a < b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BHT; i++) model_ctr[i] = 1;
      m_sb = '0;
      m_sm = '0;
      last_npc = '0;
      last_taken = 1'b0;
   endtask

   task automatic check_pred(input logic [XLEN-1:0] pc, input string tag);
      bus.pred_pc = pc;
      #1;
      check_val(tag, bus.pred_taken, model_pred(pc));
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic resolve(input logic [XLEN-1:0] pc, input logic [2:0] f3,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] imm, input logic pt);
      exp_t e;
      logic ill;
      int   ix;
      bus.res_valid      = 1'b1;
      bus.res_pc         = pc;
      bus.res_funct3     = f3;
      bus.res_rs1        = a;
      bus.res_rs2        = b;
      bus.res_imm        = imm;
      bus.res_pred_taken = pt;
      check_pred(pc, "pred_before");
      ill     = (f3 == 3'b010) || (f3 == 3'b011);
      e.taken = ill ? 1'b0 : ref_taken(f3, a, b);
      e.mis   = !ill && (e.taken != pt);
      e.ill   = ill;
      e.npc   = e.taken ? pc + imm : pc + 32'd4;
      ix = idx_of(pc);
      if (!ill) begin
         if (e.taken && model_ctr[ix] < 3) model_ctr[ix]++;
         if (!e.taken && model_ctr[ix] > 0) model_ctr[ix]--;
         if (m_sb != '1) m_sb++;
         if (e.mis && m_sm != '1) m_sm++;
      end
      e.sb = m_sb;
      e.sm = m_sm;
      sb_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.res_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Output monitor: pop expected result whenever out_valid is seen, else check hold
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               check_val("unexpected_out_valid", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check_val("out_taken", bus.out_taken, e.taken);
               check_val("out_mispredict", bus.out_mispredict, e.mis);
               check_val("out_illegal", bus.out_illegal, e.ill);
               check_val("out_next_pc", bus.out_next_pc, e.npc);
               check_val("stat_branches", stat_branches, e.sb);
               check_val("stat_mispredicts", stat_mispredicts, e.sm);
               last_npc   = e.npc;
               last_taken = e.taken;
            end
         end else begin
            check_val("hold_next_pc", bus.out_next_pc, last_npc);
            check_val("hold_taken", bus.out_taken, last_taken);
         end
      end
   end

   initial begin
      model_reset();
      rst_n              = 1'b0;
      bus.pred_pc        = 32'h100;
      bus.res_valid      = 1'b0;
      bus.res_pc         = '0;
      bus.res_funct3     = '0;
      bus.res_rs1        = '0;
      bus.res_rs2        = '0;
      bus.res_imm        = '0;
      bus.res_pred_taken = 1'b0;
      #2;
      check_val("rst_pred_taken", bus.pred_taken, 0);
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_out_taken", bus.out_taken, 0);
      check_val("rst_out_mis", bus.out_mispredict, 0);
      check_val("rst_out_ill", bus.out_illegal, 0);
      check_val("rst_next_pc", bus.out_next_pc, 0);
      check_val("rst_stat_br", stat_branches, 0);
      check_val("rst_stat_mis", stat_mispredicts, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // signed vs unsigned and equality
      resolve(32'h200, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0);
      resolve(32'h204, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b0);
      resolve(32'h208, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1);
      resolve(32'h20C, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h10, 1'b1);
      resolve(32'h210, 3'b000, 32'h5, 32'h5, 32'h20, 1'b1);
      resolve(32'h214, 3'b001, 32'h5, 32'h5, 32'h20, 1'b0);
      idle(2);

      // training on 0x40 using the live prediction, then one not-taken
      for (int i = 0; i < 3; i++) resolve(32'h40, 3'b000, 32'h7, 32'h7, 32'h8, model_pred(32'h40));
      resolve(32'h40, 3'b001, 32'h7, 32'h7, 32'h8, model_pred(32'h40));
      idle(1);
      check_pred(32'h40, "pred_after_train");
      check_val("train_pred_still_taken", bus.pred_taken, 1);

      // next PC wrap, negative offset, fall-through
      resolve(32'hFFFF_FFFC, 3'b000, 32'h0, 32'h0, 32'h8, 1'b1);
      resolve(32'h1000, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
      resolve(32'h1000, 3'b001, 32'h0, 32'h0, 32'hFFFF_FFF0, 1'b1);
      idle(1);

      // illegal funct3 leaves counters and stats alone
      resolve(32'h300, 3'b010, 32'h1, 32'h1, 32'h20, 1'b1);
      resolve(32'h300, 3'b011, 32'h1, 32'h2, 32'h20, 1'b0);
      resolve(32'h300, 3'b000, 32'h1, 32'h1, 32'h20, 1'b1);
      idle(1);

      // same-cycle predict and update on index of 0x80
      resolve(32'h80, 3'b000, 32'h3, 32'h3, 32'h4, model_pred(32'h80));
      bus.res_valid = 1'b0;
      check_pred(32'h80, "pred_next_cycle");
      check_val("same_cycle_after", bus.pred_taken, 1);
      @(negedge clk);

      // reset with a resolve in flight
      resolve(32'h40, 3'b000, 32'h1, 32'h1, 32'h40, 1'b1);
      bus.res_valid  = 1'b1;
      bus.res_pc     = 32'h44;
      bus.res_funct3 = 3'b000;
      bus.res_rs1    = 32'h9;
      bus.res_rs2    = 32'h9;
      #2;
      rst_n = 1'b0;
      model_reset();
      sb_q.delete();
      #1;
      check_val("mid_rst_out_valid", bus.out_valid, 0);
      check_val("mid_rst_out_taken", bus.out_taken, 0);
      check_val("mid_rst_out_mis", bus.out_mispredict, 0);
      check_val("mid_rst_out_ill", bus.out_illegal, 0);
      check_val("mid_rst_next_pc", bus.out_next_pc, 0);
      check_val("mid_rst_stat_br", stat_branches, 0);
      check_val("mid_rst_stat_mis", stat_mispredicts, 0);
      check_pred(32'h40, "mid_rst_pred_40");
      check_pred(32'h80, "mid_rst_pred_80");
      @(negedge clk);
      bus.res_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_no_valid", bus.out_valid, 0);
      resolve(32'h44, 3'b000, 32'h9, 32'h9, 32'h40, 1'b0);
      idle(3);
      check_val("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
